// File: rtl/reg_write_unit_pkg.sv
// reg_file_pkg: shared widths, FSM state type and one-hot decode for the register file write side.
package reg_file_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 3;
    localparam int NUM_REGS   = 1 << ADDR_WIDTH;

    typedef enum logic {IDLE, CLEAR} state_t;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_WIDTH-1:0] a);
        onehot    = '0;
        onehot[a] = 1'b1;
    endfunction
endpackage

// File: rtl/reg_write_unit_if.sv
// reg_write_unit_if: write handshake, clear request and flattened register export.
interface reg_write_unit_if;
    import reg_file_pkg::*;
    logic                           wr_valid;
    logic                           wr_ready;
    logic [ADDR_WIDTH-1:0]          wr_addr;
    logic [DATA_WIDTH-1:0]          wr_data;
    logic                           clr_req;
    logic                           busy;
    logic [NUM_REGS-1:0]            we;
    logic [NUM_REGS*DATA_WIDTH-1:0] q_all;

    modport master (
        output wr_valid, wr_addr, wr_data, clr_req,
        input  wr_ready, busy, we, q_all
    );
    modport slave (
        input  wr_valid, wr_addr, wr_data, clr_req,
        output wr_ready, busy, we, q_all
    );
endinterface

// File: rtl/reg_write_unit_write_decoder.sv
// write_decoder: gated address to one-hot write-enable decode.
module write_decoder
    import reg_file_pkg::*;
(
    input  logic                  i_en,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [NUM_REGS-1:0]   o_onehot
);
    assign o_onehot = i_en ? onehot(i_addr) : '0;
endmodule

// File: rtl/reg_write_unit.sv
// reg_write_unit: eight 32-bit registers written over valid/ready, with a sequenced
// one-register-per-cycle clear that takes priority over writes.
module reg_write_unit
    import reg_file_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    reg_write_unit_if.slave   bus
);
    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic                  w_busy;
    logic                  w_accept;
    logic [NUM_REGS-1:0]   w_we;
    logic [DATA_WIDTH-1:0] w_wdata;

    assign w_busy       = (r_state == CLEAR);
    assign bus.wr_ready = (r_state == IDLE) && !bus.clr_req;
    assign w_accept     = bus.wr_valid && bus.wr_ready;
    assign bus.busy     = w_busy;
    assign bus.we       = w_we;
    assign w_wdata      = w_busy ? '0 : bus.wr_data;

    // Single decoder shared by the write path and the clear walk.
    write_decoder u_dec (
        .i_en     (w_accept || w_busy),
        .i_addr   (w_busy ? r_clr_cnt : bus.wr_addr),
        .o_onehot (w_we)
    );

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE)
            w_next = bus.clr_req ? CLEAR : IDLE;
        else
            w_next = (r_clr_cnt == ADDR_WIDTH'(NUM_REGS - 1)) ? IDLE : CLEAR;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_busy)
                r_clr_cnt <= r_clr_cnt + 1'b1;
            else if (bus.clr_req)
                r_clr_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (w_we[i])
                    r_regs[i] <= w_wdata;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
        assign bus.q_all[DATA_WIDTH*g +: DATA_WIDTH] = r_regs[g];
    end
endmodule

// File: tb/tb_reg_write_unit.sv
// tb_reg_write_unit: directed scoreboard bench for reg_write_unit.
module tb_reg_write_unit;
    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
    } wr_item_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] mdl [8];
    wr_item_t    sb [$];
    wr_item_t    it;

    reg_write_unit_if bus ();

    reg_write_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [255:0] flat();
        logic [255:0] f;
        for (int i = 0; i < 8; i++) f[32*i +: 32] = mdl[i];
        return f;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check();
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            it = sb.pop_front();
            chk("wr_q", 256'(bus.q_all[32*it.addr +: 32]), 256'(it.data));
            mdl[it.addr] = it.data;
            chk("q_all", bus.q_all, flat());
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        bus.wr_valid = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.clr_req = 0;
        #2;
        chk("rst_q", bus.q_all, 0);
        chk("rst_busy", 256'(bus.busy), 0);
        chk("rst_we", 256'(bus.we), 0);
        chk("rst_ready", 256'(bus.wr_ready), 1);
        @(negedge clk); reset_n = 1;

        // single write
        @(negedge clk);
        bus.wr_valid = 1; bus.wr_addr = 5; bus.wr_data = 32'hDEADBEEF;
        #1;
        chk("single_we", 256'(bus.we), 256'h20);
        chk("single_ready", 256'(bus.wr_ready), 1);
        sb.push_back('{addr: 3'd5, data: 32'hDEADBEEF});
        tick();
        pop_check();
        chk("single_slice", 256'(bus.q_all[191:160]), 256'hDEADBEEF);
        bus.wr_valid = 0;

        // mid-cycle async reset
        @(negedge clk); #2;
        reset_n = 0; #1;
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        chk("async_q", bus.q_all, 0);
        chk("async_busy", 256'(bus.busy), 0);
        chk("async_we", 256'(bus.we), 0);
        @(negedge clk); reset_n = 1;

        // streaming writes
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.wr_valid = 1; bus.wr_addr = 3'(i); bus.wr_data = 32'h11111111 * (i + 1);
            #1;
            chk("stream_ready", 256'(bus.wr_ready), 1);
            chk("stream_we", 256'(bus.we), 256'(1 << i));
            sb.push_back('{addr: 3'(i), data: 32'h11111111 * (i + 1)});
            tick();
            pop_check();
        end

        // same address twice, last wins
        @(negedge clk); bus.wr_addr = 3; bus.wr_data = 32'h0BADF00D;
        sb.push_back('{addr: 3'd3, data: 32'h0BADF00D});
        tick(); pop_check();
        @(negedge clk); bus.wr_data = 32'h12345678;
        sb.push_back('{addr: 3'd3, data: 32'h12345678});
        tick(); pop_check();
        bus.wr_valid = 0;

        // clear vs write collision
        @(negedge clk);
        bus.clr_req = 1; bus.wr_valid = 1; bus.wr_addr = 2; bus.wr_data = 32'hA5A5A5A5;
        #1;
        chk("coll_ready", 256'(bus.wr_ready), 0);
        chk("coll_we", 256'(bus.we), 0);
        tick();
        chk("coll_q", bus.q_all, flat());
        @(negedge clk); bus.clr_req = 0;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk("clr_busy", 256'(bus.busy), 1);
            chk("clr_we", 256'(bus.we), 256'(1 << k));
            chk("clr_ready", 256'(bus.wr_ready), 0);
            tick();
            mdl[k] = '0;
            chk("clr_q", bus.q_all, flat());
            if (bus.q_all[95:64] === 32'hA5A5A5A5) chk("clr_no_a5", 256'(bus.q_all[95:64]), 0);
        end
        chk("clr_done_busy", 256'(bus.busy), 0);
        chk("clr_end_q", bus.q_all, 0);
        chk("held_we", 256'(bus.we), 256'h04);
        sb.push_back('{addr: 3'd2, data: 32'hA5A5A5A5});
        tick();
        pop_check();
        bus.wr_valid = 0;

        // reset mid-clear
        @(negedge clk); bus.clr_req = 1;
        tick();
        @(negedge clk); bus.clr_req = 0;
        tick(); tick(); tick();
        chk("mid_busy", 256'(bus.busy), 1);
        #2; reset_n = 0; #1;
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        chk("abort_q", bus.q_all, 0);
        chk("abort_busy", 256'(bus.busy), 0);
        chk("abort_ready", 256'(bus.wr_ready), 1);
        @(negedge clk); reset_n = 1;
        @(negedge clk);
        bus.wr_valid = 1; bus.wr_addr = 7; bus.wr_data = 32'h7777CAFE;
        #1;
        chk("post_we", 256'(bus.we), 256'h80);
        sb.push_back('{addr: 3'd7, data: 32'h7777CAFE});
        tick();
        pop_check();
        bus.wr_valid = 0;
        tick();
        chk("sb_drained", 256'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_write_unit.md
# reg_write_unit

Write side of the 8×32 register file: accepts single-register writes over a valid/ready handshake, decodes the 3-bit address to a one-hot write enable, and holds the eight registers. A sequenced clear operation zeroes all registers, one register per cycle. All registers are exported flattened, so the 8-to-1 read multiplexers can select from them.

## Interface
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 3, register address width; NUM_REGS = 2**ADDR_WIDTH (8)

Ports:
- clk  in  1  rising-edge clock, single clock domain
- reset_n  in  1  asynchronous, active-low reset
- wr_valid  in  1  write request present
- wr_ready  out  1  unit can accept a write this cycle
- wr_addr  in  ADDR_WIDTH  target register index
- wr_data  in  DATA_WIDTH  write data
- clr_req  in  1  request to zero all registers (sampled as a level)
- busy  out  1  clear sequence in progress
- we  out  NUM_REGS  one-hot write enable applied at the coming edge (0 when no write)
- q_all  out  NUM_REGS*DATA_WIDTH  register i at bits [DATA_WIDTH*i+DATA_WIDTH-1 : DATA_WIDTH*i]

## Operation
- State machine states:
  - IDLE: normal writes.
  - CLEAR: sequenced zeroing.
- Internal state: ADDR_WIDTH-bit counter clr_cnt; registers reg[0..7].
- wr_ready = (state==IDLE) && !clr_req. This is combinational, and clear takes priority over a write.
- Write accept:
  - A write is accepted when wr_valid && wr_ready at a rising edge; reg[wr_addr] <= wr_data at that edge.
  - No partial or byte writes.
  - wr_data is not altered.
- IDLE → CLEAR when clr_req=1 at an edge:
  - clr_cnt <= 0.
  - No register changes at that edge.
  - A simultaneous wr_valid is not accepted; the writer must hold its request.
- CLEAR:
  - Each edge: reg[clr_cnt] <= 0 and clr_cnt <= clr_cnt+1.
  - On the edge that zeroes reg[NUM_REGS-1]: state <= IDLE and clr_cnt wraps to 0.
- clr_req is ignored while in CLEAR; it does not restart or extend the sequence.
- busy = (state==CLEAR).
- we:
  - IDLE with an accepted write: onehot(wr_addr).
  - CLEAR: onehot(clr_cnt).
  - Otherwise: 0.
  - Never more than one bit set.
- q_all is the direct register contents. No bypass: a write becomes visible after the edge that performs it.

## Timing
- Reset (asynchronous assert, released synchronously by the environment):
  - All registers 0, state IDLE, clr_cnt 0.
  - Outputs: q_all=0, busy=0, we=0, wr_ready=!clr_req.
- Write latency: 1 edge from acceptance to the new value on q_all. Back-to-back writes are sustained at 1 per cycle in IDLE.
- Clear duration:
  - 1 edge to enter CLEAR, then 8 edges of zeroing.
  - busy is high for exactly 8 cycles.
  - wr_ready goes high again the cycle after the final zeroing edge, unless clr_req is still high, in which case a new clear begins.
- Writes to the same address on consecutive cycles: the last one wins.
- Reset asserted during CLEAR: immediate abort; all registers are 0, state IDLE.

## Structure
- Shared package reg_file_pkg:
  - DATA_WIDTH and ADDR_WIDTH defaults.
  - State typedef {IDLE, CLEAR}.
  - onehot decode function.
- One sub-module, write_decoder: ADDR_WIDTH to NUM_REGS one-hot with an enable input. It is instantiated once, fed by a mux of wr_addr/clr_cnt; its output drives we.
- Register storage and the FSM live in reg_write_unit.

## Test plan
- Reset: hold reset_n=0 mid-cycle → q_all=0, busy=0, we=0 immediately, without waiting for a clock edge.
- Single write: addr=5, data=0xDEADBEEF, valid 1 cycle → we=8'b0010_0000 that cycle; bits [191:160]=0xDEADBEEF after the edge; other registers 0.
- Streaming writes: addr 0..7 with data 0x11111111×(i+1) on consecutive cycles → all accepted (wr_ready=1 throughout); q_all holds all eight values after 8 edges.
- Clear vs write collision: registers preloaded; assert clr_req and wr_valid (addr=2, data=0xA5A5A5A5) in the same cycle → wr_ready=0; busy=1 for 8 cycles; we walks 0x01→0x80; q_all=0 at the end; reg2 is never 0xA5A5A5A5.
- Reset mid-clear: start a clear, assert reset_n=0 after 3 zeroing edges → state IDLE, q_all=0, busy=0; a write to addr=7 after release lands normally.
